// File: rtl/inst_buffer_if.sv
// Fetch/decode-facing signal bundle for the instruction buffer.
// master = fetch + decode + branch resolution; slave = the buffer itself.
interface inst_buffer_if #(
    parameter int PTR_W = 4
);
    logic             push;
    logic [31:0]      push_data;
    logic             full;
    logic             pop;
    logic [31:0]      head_data;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             flush;

    modport master (
        output push, push_data, pop, flush,
        input  full, head_data, empty, count
    );

    modport slave (
        input  push, push_data, pop, flush,
        output full, head_data, empty, count
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and decode, flushed on taken branches.
// full/empty depend only on the registered count, so fetch and decode never share a comb path.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    inst_buffer_if.slave  bus
);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             full_s, empty_s;
    logic             push_eff_s, pop_eff_s;

    // Occupancy flags and the qualified push/pop strobes.
    always_comb begin
        full_s     = (count_q == DEPTH_C);
        empty_s    = (count_q == {(PTR_W+1){1'b0}});
        // A push while full is dropped even with a pop: fetch will retry it.
        push_eff_s = bus.push & ~full_s  & ~bus.flush;
        pop_eff_s  = bus.pop  & ~empty_s & ~bus.flush;
    end

    // Next-state for pointers and occupancy; flush outranks push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = {(PTR_W+1){1'b0}};
        end else begin
            if (push_eff_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_eff_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not cleared by reset; stale slots are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (push_eff_s && !reset) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
    assign bus.count     = count_q;
    assign bus.head_data = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_inst_buffer;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] model_q [$];

    inst_buffer_if #(.PTR_W(PTR_W)) bus ();

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the queue rules, compare after the edge.
    task automatic step(input logic p, input logic [31:0] d, input logic po,
                        input logic fl, input logic rs);
        logic do_push;
        logic do_pop;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = po;
        bus.flush     = fl;
        reset         = rs;
        do_push = p  && (model_q.size() < DEPTH);
        do_pop  = po && (model_q.size() > 0);
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
        reset     = 1'b0;
        check("count", 32'(bus.count), 32'(model_q.size()));
        check("empty", 32'(bus.empty), 32'(model_q.size() == 0));
        check("full",  32'(bus.full),  32'(model_q.size() == DEPTH));
        if (model_q.size() > 0) check("head", bus.head_data, model_q[0]);
    endtask

    task automatic do_push(input logic [31:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.push = 1'b0; bus.push_data = 32'h0; bus.pop = 1'b0; bus.flush = 1'b0;
        reset = 1'b1;

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full),  32'd0);

        // Fill / drain
        do_push(32'h0000_1111); check("fd_cnt1", 32'(bus.count), 32'd1);
        check("fd_head1", bus.head_data, 32'h0000_1111);
        do_push(32'h0001_2222); check("fd_cnt2", 32'(bus.count), 32'd2);
        do_push(32'h0002_3333); check("fd_cnt3", 32'(bus.count), 32'd3);
        do_pop(); check("fd_head2", bus.head_data, 32'h0001_2222); check("fd_cnt4", 32'(bus.count), 32'd2);
        do_pop(); check("fd_head3", bus.head_data, 32'h0002_3333); check("fd_cnt5", 32'(bus.count), 32'd1);
        do_pop(); check("fd_cnt6", 32'(bus.count), 32'd0); check("fd_empty", 32'(bus.empty), 32'd1);

        // Full retry
        for (int i = 0; i < DEPTH; i++) do_push({16'(i), 16'h5A5A});
        check("fr_full", 32'(bus.full), 32'd1);
        check("fr_cnt16", 32'(bus.count), 32'd16);
        step(1'b1, 32'h0010_AAAA, 1'b1, 1'b0, 1'b0);
        check("fr_cnt15", 32'(bus.count), 32'd15);
        check("fr_nfull", 32'(bus.full), 32'd0);
        do_push(32'h0010_AAAA);
        check("fr_cnt16b", 32'(bus.count), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            check("fr_drain_pc", 32'(bus.head_data[31:16]), 32'(i));
            do_pop();
        end
        check("fr_drained", 32'(bus.empty), 32'd1);

        // Wrap-around with occupancy held at 3
        for (int i = 0; i < 3; i++) do_push({16'(100 + i), 16'h0});
        for (int k = 0; k < 40; k++) begin
            check("wr_pc", 32'(bus.head_data[31:16]), 32'(100 + k));
            step(1'b1, {16'(103 + k), 16'h0}, 1'b1, 1'b0, 1'b0);
            check("wr_cnt", 32'(bus.count), 32'd3);
        end

        // Flush priority with 5 entries
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_push({16'(i), 16'hF00D});
        step(1'b1, 32'h0005_BEEF, 1'b1, 1'b1, 1'b0);
        check("fl_empty", 32'(bus.empty), 32'd1);
        check("fl_cnt",   32'(bus.count), 32'd0);
        check("fl_full",  32'(bus.full),  32'd0);
        do_push(32'h0040_CAFE);
        check("fl_head", bus.head_data, 32'h0040_CAFE);

        // Empty / one-entry corner
        do_pop();
        do_pop();
        check("em_cnt", 32'(bus.count), 32'd0);
        do_push(32'h0001_0001);
        step(1'b1, 32'h0002_0002, 1'b1, 1'b0, 1'b0);
        check("one_cnt",  32'(bus.count), 32'd1);
        check("one_head", bus.head_data, 32'h0002_0002);

        // Reset mid-operation
        for (int i = 0; i < 9; i++) do_push({16'(i), 16'h7777});
        check("rm_cnt10", 32'(bus.count), 32'd10);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rm_empty", 32'(bus.empty), 32'd1);
        check("rm_cnt",   32'(bus.count), 32'd0);
        do_push(32'h0000_0001);
        check("rm_head", bus.head_data, 32'h0000_0001);

        // Random traffic, biased toward pushes so the buffer reaches full
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(99) < 60), $urandom(), ($urandom_range(99) < 45),
                 ($urandom_range(99) < 3), ($urandom_range(199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
